// File: rtl/riscv_core_fetch_pkg.sv
// Shared definitions for the fetch-side decoupling buffer: the NOP encoding
// presented to Decode when no instruction is valid, the default buffer depth,
// and the layout of one buffered fetch entry.
package riscv_core_fetch_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] RISCV_NOP       = 32'h00000013;
  localparam int          FETCH_BUF_DEPTH = 2;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_core_fetch_fifo.sv
// Small synchronous FIFO used twice by the fetch buffer: once to remember
// the PC of every in-flight imem request, and once to hold instructions
// while Decode is stalled. DEPTH is a power of two, so pointers wrap
// naturally. clear empties the FIFO and takes priority over enq/deq.
// The caller guarantees no enq when full and no deq when empty.
module riscv_core_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_enq,
  input  logic [WIDTH-1:0]           i_enq_data,
  input  logic                       i_deq,
  input  logic                       i_clear,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Pointer and occupancy bookkeeping; clear resets both pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_enq) r_wptr <= r_wptr + AW'(1);
      if (i_deq) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(i_enq) - CW'(i_deq);
    end
  end

  // Storage array; contents need no reset because count gates their use.
  always_ff @(posedge clk) begin
    if (i_enq && !i_clear) r_mem[r_wptr] <= i_enq_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/riscv_core_fetch_buffer.sv
// Fetch-side decoupling buffer between the imem port and Decode.
//
// Handshakes: a transfer on a val/rdy pair happens in exactly the cycle where
// both are high. imem responses have no ready and are always consumed.
// Decode consumes inst_Dhl in a cycle where inst_val_Dhl and inst_rdy_Dhl are
// both high.
//
// Credits: a request may issue only while buffered + in-flight < DEPTH, so
// every in-flight response is guaranteed a buffer slot if Decode stalls.
// On a squash every in-flight request becomes stale; drop counts how many
// responses must still be thrown away before real ones return.
module riscv_core_fetch_buffer
  import riscv_core_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_BUF_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_val_Fhl,
  input  logic [31:0] fetch_addr_Fhl,
  output logic        fetch_rdy_Fhl,
  input  logic        squash_Fhl,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_msg_addr,
  input  logic        imemresp_val,
  input  logic [31:0] imemresp_msg_data,
  output logic        inst_val_Dhl,
  input  logic        inst_rdy_Dhl,
  output logic [31:0] inst_Dhl,
  output logic [31:0] pc_Dhl
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_occ;
  logic [CW-1:0] w_pcq_count;
  logic [CW:0]   w_credit_sum;
  logic [31:0]   w_resp_pc;
  logic          w_req_fire;
  logic          w_resp;
  logic          w_resp_drop;
  logic          w_resp_keep;
  logic          w_buf_empty;
  logic          w_flow;
  logic          w_enq;
  logic          w_deq;
  fetch_entry_t  w_enq_entry;
  fetch_entry_t  w_head;

  // ---------------------------------------------------------------- request
  assign w_credit_sum     = {1'b0, w_occ} + {1'b0, r_out};
  assign fetch_rdy_Fhl    = (w_credit_sum < (CW+1)'(DEPTH));
  assign imemreq_val      = fetch_val_Fhl & fetch_rdy_Fhl & ~reset;
  assign imemreq_msg_addr = fetch_addr_Fhl;
  assign w_req_fire       = imemreq_val & imemreq_rdy;

  // --------------------------------------------------------------- response
  // A response with nothing in flight has no PC to pair with and is ignored.
  assign w_resp      = imemresp_val & (w_pcq_count != '0);
  assign w_resp_drop = w_resp & ((r_drop != '0) | squash_Fhl);
  assign w_resp_keep = w_resp & ~w_resp_drop;
  assign w_buf_empty = (w_occ == '0);
  assign w_flow      = w_resp_keep & w_buf_empty & inst_rdy_Dhl;
  assign w_enq       = w_resp_keep & ~w_flow;
  assign w_deq       = ~w_buf_empty & inst_rdy_Dhl & ~squash_Fhl;

  assign w_enq_entry = '{pc: w_resp_pc, inst: imemresp_msg_data};

  // PC of every issued request, popped in order as responses return.
  riscv_core_fetch_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_enq      (w_req_fire),
    .i_enq_data (fetch_addr_Fhl),
    .i_deq      (w_resp),
    .i_clear    (1'b0),
    .o_head     (w_resp_pc),
    .o_count    (w_pcq_count)
  );

  // Valid instructions waiting for Decode; flushed on a redirect.
  riscv_core_fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_buf (
    .clk        (clk),
    .reset      (reset),
    .i_enq      (w_enq),
    .i_enq_data (w_enq_entry),
    .i_deq      (w_deq),
    .i_clear    (squash_Fhl),
    .o_head     (w_head),
    .o_count    (w_occ)
  );

  // In-flight and stale-in-flight counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out  <= '0;
      r_drop <= '0;
    end else begin
      r_out <= r_out + CW'(w_req_fire) - CW'(w_resp);
      if (squash_Fhl) begin
        // Everything already in flight is stale; a response this cycle is
        // discarded right now, and a redirect request firing now is live.
        r_drop <= r_out - CW'(w_resp);
      end else if (w_resp && (r_drop != '0)) begin
        r_drop <= r_drop - CW'(1);
      end
    end
  end

  // Decode-side mux: buffer head first, else the flow-through response.
  always_comb begin
    inst_val_Dhl = 1'b0;
    inst_Dhl     = RISCV_NOP;
    pc_Dhl       = 32'h0;
    if (!squash_Fhl) begin
      if (!w_buf_empty) begin
        inst_val_Dhl = 1'b1;
        inst_Dhl     = w_head.inst;
        pc_Dhl       = w_head.pc;
      end else if (w_flow) begin
        inst_val_Dhl = 1'b1;
        inst_Dhl     = imemresp_msg_data;
        pc_Dhl       = w_resp_pc;
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_fetch_buffer.sv
// Directed bench for riscv_core_fetch_buffer (DEPTH = 2): streaming, decode
// stall, squash with stale responses, squash with a coinciding response,
// buffer flush on squash, request backpressure and asynchronous reset.
module tb_riscv_core_fetch_buffer;
  import riscv_core_fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_val_Fhl;
  logic [31:0] fetch_addr_Fhl;
  logic        fetch_rdy_Fhl;
  logic        squash_Fhl;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_msg_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_msg_data;
  logic        inst_val_Dhl;
  logic        inst_rdy_Dhl;
  logic [31:0] inst_Dhl;
  logic [31:0] pc_Dhl;

  logic [63:0] exp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  // ------------------------------------------------------ clock and reset
  always #5 clk = ~clk;

  riscv_core_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_val_Fhl     (fetch_val_Fhl),
    .fetch_addr_Fhl    (fetch_addr_Fhl),
    .fetch_rdy_Fhl     (fetch_rdy_Fhl),
    .squash_Fhl        (squash_Fhl),
    .imemreq_val       (imemreq_val),
    .imemreq_rdy       (imemreq_rdy),
    .imemreq_msg_addr  (imemreq_msg_addr),
    .imemresp_val      (imemresp_val),
    .imemresp_msg_data (imemresp_msg_data),
    .inst_val_Dhl      (inst_val_Dhl),
    .inst_rdy_Dhl      (inst_rdy_Dhl),
    .inst_Dhl          (inst_Dhl),
    .pc_Dhl            (pc_Dhl)
  );

  // ------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // ---------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [31:0] fa, input logic rv, input logic [31:0] rd);
    fetch_val_Fhl     = fv;
    fetch_addr_Fhl    = fa;
    imemresp_val      = rv;
    imemresp_msg_data = rd;
    #1;
  endtask

  task automatic idle();
    squash_Fhl   = 1'b0;
    imemreq_rdy  = 1'b1;
    inst_rdy_Dhl = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // ----------------------------------------- scoreboard and invariants
  always @(negedge clk) begin
    if (!reset) begin
      check("inv_credit", 64'((dut.w_occ + dut.r_out) <= DEPTH), 64'd1);
      check("inv_drop_le_out", 64'(dut.r_drop <= dut.r_out), 64'd1);
      if (imemresp_val) check("inv_resp_with_out", 64'(dut.r_out != 0), 64'd1);
      if (inst_val_Dhl && inst_rdy_Dhl) begin
        if (exp_q.size() == 0) check("unexpected_inst", 64'(exp_q.size()), 64'd1);
        else check("decode_stream", {pc_Dhl, inst_Dhl}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench timed out");
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    fetch_val_Fhl = 1'b1;
    #1;
    check("rst_reqval_held", 64'(imemreq_val), 64'd0);
    fetch_val_Fhl = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_fetch_rdy", 64'(fetch_rdy_Fhl), 64'd1);
    check("rst_inst_val", 64'(inst_val_Dhl), 64'd0);
    check("rst_inst_nop", 64'(inst_Dhl), 64'h13);
    check("rst_pc", 64'(pc_Dhl), 64'd0);
    check("rst_out", 64'(dut.r_out), 64'd0);
    check("rst_occ", 64'(dut.w_occ), 64'd0);
    check("rst_drop", 64'(dut.r_drop), 64'd0);
    tick();

    // Streaming, 1-cycle imem latency, Decode always ready.
    drive(1'b1, 32'h80000, 1'b0, 32'h0);
    check("s_req0_val", 64'(imemreq_val), 64'd1);
    check("s_req0_addr", 64'(imemreq_msg_addr), 64'h80000);
    tick();
    exp_q.push_back({32'h80000, 32'h00100093});
    drive(1'b1, 32'h80004, 1'b1, 32'h00100093);
    check("s_flow0_val", 64'(inst_val_Dhl), 64'd1);
    check("s_flow0_pc", 64'(pc_Dhl), 64'h80000);
    check("s_req1_addr", 64'(imemreq_msg_addr), 64'h80004);
    tick();
    exp_q.push_back({32'h80004, 32'h00200113});
    drive(1'b1, 32'h80008, 1'b1, 32'h00200113);
    check("s_flow1_val", 64'(inst_val_Dhl), 64'd1);
    tick();
    exp_q.push_back({32'h80008, 32'h00300193});
    drive(1'b0, 32'h0, 1'b1, 32'h00300193);
    check("s_flow2_val", 64'(inst_val_Dhl), 64'd1);
    check("s_flow2_inst", 64'(inst_Dhl), 64'h00300193);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check("s_out_idle", 64'(dut.r_out), 64'd0);

    // Decode stall: two entries buffered, credits exhausted.
    inst_rdy_Dhl = 1'b0;
    drive(1'b1, 32'h80000, 1'b0, 32'h0);
    check("st_req0_val", 64'(imemreq_val), 64'd1);
    tick();
    drive(1'b1, 32'h80004, 1'b1, 32'hA0000001);
    check("st_noflow_val", 64'(inst_val_Dhl), 64'd0);
    check("st_req1_val", 64'(imemreq_val), 64'd1);
    tick();
    drive(1'b1, 32'h80008, 1'b1, 32'hA0000002);
    check("st_rdy_low", 64'(fetch_rdy_Fhl), 64'd0);
    check("st_no_req2", 64'(imemreq_val), 64'd0);
    check("st_head_val", 64'(inst_val_Dhl), 64'd1);
    check("st_head_inst", 64'(inst_Dhl), 64'hA0000001);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h80008, 1'b0, 32'h0);
      check("st_occ_full", 64'(dut.w_occ), 64'd2);
      check("st_rdy_held", 64'(fetch_rdy_Fhl), 64'd0);
      check("st_no_req_held", 64'(imemreq_val), 64'd0);
      tick();
    end
    exp_q.push_back({32'h80000, 32'hA0000001});
    exp_q.push_back({32'h80004, 32'hA0000002});
    inst_rdy_Dhl = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check("st_drain0_pc", 64'(pc_Dhl), 64'h80000);
    tick();
    check("st_drain1", {pc_Dhl, inst_Dhl}, {32'h80004, 32'hA0000002});
    tick();
    check("st_occ_empty", 64'(dut.w_occ), 64'd0);

    // Squash with two in flight; redirect target issues once a credit frees.
    drive(1'b1, 32'h80000, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h80004, 1'b0, 32'h0);
    check("sq_req1_val", 64'(imemreq_val), 64'd1);
    tick();
    squash_Fhl = 1'b1;
    drive(1'b1, 32'h80100, 1'b0, 32'h0);
    check("sq_no_credit", 64'(imemreq_val), 64'd0);
    check("sq_val_forced", 64'(inst_val_Dhl), 64'd0);
    tick();
    squash_Fhl = 1'b0;
    check("sq_drop2", 64'(dut.r_drop), 64'd2);
    drive(1'b1, 32'h80100, 1'b1, 32'hDEAD0000);
    check("sq_stale0_val", 64'(inst_val_Dhl), 64'd0);
    tick();
    check("sq_drop1", 64'(dut.r_drop), 64'd1);
    drive(1'b1, 32'h80100, 1'b1, 32'hDEAD0004);
    check("sq_target_req", 64'(imemreq_val), 64'd1);
    check("sq_stale1_val", 64'(inst_val_Dhl), 64'd0);
    tick();
    check("sq_drop0", 64'(dut.r_drop), 64'd0);
    exp_q.push_back({32'h80100, 32'hB0000000});
    drive(1'b0, 32'h0, 1'b1, 32'hB0000000);
    check("sq_target_val", 64'(inst_val_Dhl), 64'd1);
    check("sq_target_pc", 64'(pc_Dhl), 64'h80100);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check("sq_out_idle", 64'(dut.r_out), 64'd0);

    // Squash in the same cycle as the only outstanding response.
    drive(1'b1, 32'h80200, 1'b0, 32'h0);
    tick();
    squash_Fhl = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 32'h5A5A5A5A);
    check("sqr_val_forced", 64'(inst_val_Dhl), 64'd0);
    tick();
    squash_Fhl = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check("sqr_drop", 64'(dut.r_drop), 64'd0);
    check("sqr_out", 64'(dut.r_out), 64'd0);
    check("sqr_occ", 64'(dut.w_occ), 64'd0);

    // Squash flushes a buffered instruction.
    inst_rdy_Dhl = 1'b0;
    drive(1'b1, 32'h80500, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'hE0000000);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check("fl_occ1", 64'(dut.w_occ), 64'd1);
    check("fl_val_before", 64'(inst_val_Dhl), 64'd1);
    squash_Fhl = 1'b1;
    #1;
    check("fl_val_forced", 64'(inst_val_Dhl), 64'd0);
    tick();
    squash_Fhl = 1'b0;
    #1;
    check("fl_occ0", 64'(dut.w_occ), 64'd0);
    check("fl_val_after", 64'(inst_val_Dhl), 64'd0);
    inst_rdy_Dhl = 1'b1;

    // imem backpressure for three cycles.
    imemreq_rdy = 1'b0;
    drive(1'b1, 32'h80300, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("bp_val_held", 64'(imemreq_val), 64'd1);
      tick();
      check("bp_out_still", 64'(dut.r_out), 64'd0);
    end
    imemreq_rdy = 1'b1;
    #1;
    check("bp_fire_val", 64'(imemreq_val), 64'd1);
    tick();
    check("bp_out1", 64'(dut.r_out), 64'd1);
    exp_q.push_back({32'h80300, 32'hC0000000});
    drive(1'b0, 32'h0, 1'b1, 32'hC0000000);
    check("bp_flow_val", 64'(inst_val_Dhl), 64'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check("bp_out_idle", 64'(dut.r_out), 64'd0);

    // Asynchronous reset with one buffered and one in flight.
    inst_rdy_Dhl = 1'b0;
    drive(1'b1, 32'h80400, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h80404, 1'b1, 32'h70000000);
    tick();
    drive(1'b1, 32'h80408, 1'b0, 32'h0);
    check("rm_occ1", 64'(dut.w_occ), 64'd1);
    check("rm_out1", 64'(dut.r_out), 64'd1);
    check("rm_val_before", 64'(inst_val_Dhl), 64'd1);
    reset = 1'b1;
    #1;
    check("rm_val", 64'(inst_val_Dhl), 64'd0);
    check("rm_inst_nop", 64'(inst_Dhl), 64'h13);
    check("rm_pc", 64'(pc_Dhl), 64'd0);
    check("rm_reqval", 64'(imemreq_val), 64'd0);
    check("rm_occ0", 64'(dut.w_occ), 64'd0);
    check("rm_out0", 64'(dut.r_out), 64'd0);
    tick();
    reset = 1'b0;
    inst_rdy_Dhl = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check("rm_fetch_rdy", 64'(fetch_rdy_Fhl), 64'd1);
    check("rm_val_after", 64'(inst_val_Dhl), 64'd0);
    tick();

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/riscv_core_fetch_buffer.md
# riscv_core_fetch_buffer

Fetch-side decoupling buffer between the instruction memory port and the Decode stage of the 5-stage RISCV core. Issues imem requests under a credit limit, tags each in-flight request with its PC, discards responses belonging to squashed (redirected) fetches, and buffers valid instructions while Decode is stalled. It presents an in-order instruction/PC stream to Decode over a val/rdy interface.

## Interface
- `DEPTH`, default 2: buffer entries; power of two, ≥ 2; also the maximum number of in-flight requests.
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_val_Fhl`  in  1  control wants to issue a fetch this cycle.
- `fetch_addr_Fhl`  in  32  PC of the fetch; this is the PC mux output.
- `fetch_rdy_Fhl`  out  1  a credit is available; when low, control stalls F.
- `squash_Fhl`  in  1  redirect. All in-flight and buffered instructions are stale.
- `imemreq_val`  out  1  imem request valid.
- `imemreq_rdy`  in  1  imem accepts the request.
- `imemreq_msg_addr`  out  32  request address; equals `fetch_addr_Fhl`.
- `imemresp_val`  in  1  imem response valid; always accepted, with no backpressure.
- `imemresp_msg_data`  in  32  instruction word.
- `inst_val_Dhl`  out  1  instruction valid to Decode.
- `inst_rdy_Dhl`  in  1  Decode consumes; this is `!stall_Dhl`.
- `inst_Dhl`  out  32  instruction; `32'h00000013` (NOP) when `inst_val_Dhl` is low.
- `pc_Dhl`  out  32  PC of `inst_Dhl`; `0` when invalid.

## Operation
- State:
  - `occ`: count of buffered valid instructions.
  - `out`: count of requests in flight, stale ones included.
  - `drop`: count of stale requests in flight.
  - All three counters are `$clog2(DEPTH)+1` bits wide.
- Credit: `fetch_rdy_Fhl = (occ + out < DEPTH)`.
- Request: `imemreq_val = fetch_val_Fhl & fetch_rdy_Fhl`. A request fires on `imemreq_val & imemreq_rdy`. When it fires, `fetch_addr_Fhl` is pushed onto the in-flight PC FIFO and `out` increments.
- Response: `imemresp_val` pops the in-flight PC FIFO and decrements `out`.
  - If `drop > 0`, or `squash_Fhl` is high in the same cycle, the response is discarded and `drop` decrements when it was nonzero.
  - Otherwise, if `occ == 0` and `inst_rdy_Dhl` is high, the response flows through to Decode in the same cycle and is not enqueued.
  - Otherwise `{pc, data}` is enqueued.
- Decode output: head of the buffer, or the flow-through response when the buffer is empty. `inst_val_Dhl` is forced to 0 in any cycle where `squash_Fhl` is high.
- Squash cycle:
  - The buffer is cleared, so `occ = 0`.
  - `drop_next = out - imemresp_val`: every in-flight request becomes stale except one that responds this cycle, which is dropped immediately.
  - A request firing in the squash cycle (the redirect target) is not stale. `out` counts it, `drop` does not.
- Invariants, asserted by the bench:
  - `occ + out ≤ DEPTH`
  - `drop ≤ out`
  - no response while `out == 0`

## Timing
- Reset values: `occ = out = drop = 0`, `inst_val_Dhl = 0`, `imemreq_val = 0`, `fetch_rdy_Fhl = 1` (after deassert), `inst_Dhl = NOP`, `pc_Dhl = 0`. `imemreq_val` is held at 0 while `reset` is high.
- Reset mid-operation: all state clears. Responses still owed by imem are not tracked, so the core asserts reset only together with the memory system.
- Request to response latency is at least 1 cycle and is otherwise arbitrary. Responses return in order.
- Latency from response to Decode is 0 cycles when the buffer is empty and Decode is ready. Otherwise the instruction is presented from the buffer 1 cycle later, in FIFO order.
- Simultaneous enqueue and dequeue at `occ == DEPTH` cannot occur, because credits prevent it. Simultaneous enqueue and dequeue at `0 < occ < DEPTH` leaves `occ` unchanged.
- Pointers wrap modulo `DEPTH`.

## Structure
- Shared package `riscv_core_fetch_pkg`:
  - `RISCV_NOP = 32'h00000013`
  - `FETCH_BUF_DEPTH = 2`
  - a fetch-entry typedef of `{pc[31:0], inst[31:0]}`
- One sub-module, `riscv_core_fetch_fifo` (parameters `WIDTH`, `DEPTH`; ports: enq, deq, clear, head, count). It is instantiated twice: as the in-flight PC FIFO (32 bits) and as the instruction buffer (64 bits).
- The top level holds the `out` and `drop` counters, the flow-through mux, and the squash logic.

## Test plan
- Streaming: issue 0x80000, 0x80004, 0x80008 back-to-back with 1-cycle imem latency and `inst_rdy_Dhl = 1` -> Decode sees all three in order, each with zero added latency and the correct `pc_Dhl`.
- Decode stall: hold `inst_rdy_Dhl = 0` for 4 cycles with DEPTH = 2 -> two entries are buffered, `fetch_rdy_Fhl` drops to 0, and no third request issues. On release, the entries drain in order.
- Squash with 2 in flight: fire 0x80000 and 0x80004, squash with a new request to 0x80100, then return three responses -> the first two are dropped (`drop` goes 2→1→0) and only 0x80100 reaches Decode.
- Squash coinciding with a response: 1 in flight, `squash_Fhl` and `imemresp_val` in the same cycle -> the response is discarded, `drop = 0`, and `inst_val_Dhl = 0` that cycle.
- Backpressure: `imemreq_rdy = 0` for 3 cycles -> `out` does not change, and the request fires on the first cycle `imemreq_rdy` is high.
- Reset mid-stream: assert `reset` asynchronously with 1 buffered instruction and 1 in flight -> all outputs immediately take their reset values, and `fetch_rdy_Fhl = 1` after deassert.
